serial_frame_rx: RTL
====================

Name: serial_frame_rx

Overview:
- Receive end of the one-bit-per-clock serial link driven by the existing frame transmitter.
- Line format:
  - idle = 0
  - start bit = 1 (one clock)
  - DATA_BITS data bits, LSB first, one clock each
  - stop bit = 0 (one clock)
- Block recovers each byte and presents it on a valid/ready output register.
- Flags framing errors and overruns. Sits beside the transmitter for loopback and board-to-board links.

Parameters:
- DATA_BITS, 8, payload bits per frame (1..16).
- SYNC_STAGES, 2, flops on rxd before use (0 = use rxd directly; same clock domain as transmitter).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- rxd  input  1  serial line.
- rx_data  output  DATA_BITS  received payload; stable while rx_valid=1.
- rx_valid  output  1  rx_data holds an unconsumed frame.
- rx_ready  input  1  consumer accepts rx_data on a clock edge where rx_valid=1.
- busy  output  1  1 while state is DATA or STOP.
- frame_err  output  1  one-cycle pulse: stop bit sampled as 1.
- overrun  output  1  one-cycle pulse: good frame completed while output register was full and not being consumed.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; synchronizer flops=0 (idle level); shift register, bit counter and rx_data = 0.
  - rx_valid=0, frame_err=0, overrun=0, busy=0.
  - A reset mid-frame discards the partial frame. After release, the block hunts for a fresh start bit.
- Sampling: s = rxd delayed by SYNC_STAGES flops. All decisions below use s, one bit per clock, no oversampling.
- States:
  - IDLE: s=1 -> DATA, bit_cnt=0. s=0 -> stay.
  - DATA: store s into shift[bit_cnt]; bit_cnt+1.
    - After the DATA_BITS-th bit -> STOP.
    - Data bits are never validated.
  - STOP:
    - s=0: frame good -> IDLE. Payload offered to the output register.
    - s=1: frame_err pulses next cycle; payload discarded -> HUNT.
  - HUNT: stay while s=1; s=0 -> IDLE.
    - Prevents a stuck-high line from re-triggering frames.
- Back-to-back: a start bit sampled on the cycle after a good stop bit is accepted. The transmitter's minimum gap is one idle cycle, so this is satisfied with margin.
- Latency: first sampled start bit at edge E -> rx_valid=1 after edge E+DATA_BITS+1. With SYNC_STAGES=0 that is 10 clocks after rxd rises (DATA_BITS=8); add SYNC_STAGES.
- Output register (on a good stop bit):
  - If rx_valid=0, or rx_valid=1 and rx_ready=1 on the same edge: load rx_data, rx_valid=1 (load wins over consume).
  - If rx_valid=1 and rx_ready=0: new payload dropped, held rx_data unchanged, overrun pulses one cycle.
  - Consume without load: rx_valid=1 and rx_ready=1 -> rx_valid=0 next cycle; rx_data keeps its last value.
- rx_ready is ignored while rx_valid=0.
- frame_err and overrun are registered single-cycle pulses. They never coincide, since each comes from a distinct stop-bit outcome.
- busy is registered from state, not from s.

Test Plan:
1. SYNC_STAGES=0, rx_ready=1; line 0,1,1,0,1,0,0,1,0,1,0 (idle, start, bits of 0xA5 LSB first, stop) -> rx_data=0xA5; rx_valid rises exactly 10 clocks after the start bit and is high one cycle; frame_err=overrun=0.
2. Loopback from the existing transmitter with SYNC_STAGES=2, frames 0x00, 0xFF, 0x3C sent with minimum gap -> three rx_valid pulses, in order, with matching data; no errors.
3. Frame 0x81 with stop bit forced 1, then line held 1 for 5 clocks, then 0, then a good 0x42 frame -> frame_err pulses once; no rx_valid for the bad frame; no false start while held high; 0x42 delivered.
4. rx_ready=0; send 0x11 then 0x22 -> rx_data stays 0x11 with rx_valid=1; overrun pulses one cycle at the end of 0x22. Raise rx_ready -> rx_valid drops the next cycle.
5. rx_valid=1 holding 0x33; rx_ready=1 on exactly the edge 0x44 completes -> rx_data=0x44, rx_valid stays 1, overrun=0.
6. Assert rst=0 asynchronously after the 4th data bit of a frame, release, then send 0x5A -> all outputs 0 during reset; partial frame discarded; 0x5A received correctly.

Source files
------------

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: receive end of the one-bit-per-clock serial link.
// Line format: idle 0, start 1, DATA_BITS data bits LSB first, stop 0.
// The recovered payload is presented on a valid/ready output register;
// bad stop bits and dropped payloads are reported as one-cycle pulses.
module serial_frame_rx #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP,
        HUNT
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 s;
    logic [CNT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 cnt_clr;
    logic                 shift_en;
    logic                 stop_good;
    logic                 stop_bad;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = rxd;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync;

            // Synchronizer chain on rxd; resets to the idle line level.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sync <= '0;
                end else begin
                    sync <= (sync << 1) | SYNC_STAGES'(rxd);
                end
            end

            assign s = sync[SYNC_STAGES-1];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode from the sampled line.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (s) state_next = DATA;
            DATA:    if (bit_cnt == LAST_BIT) state_next = STOP;
            STOP:    state_next = s ? HUNT : IDLE;
            HUNT:    if (!s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Per-state control strobes for the datapath and output register.
    always_comb begin
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        stop_good = 1'b0;
        stop_bad  = 1'b0;
        case (state)
            IDLE:    cnt_clr = 1'b1;
            DATA:    shift_en = 1'b1;
            STOP: begin
                stop_good = !s;
                stop_bad  = s;
            end
            default: ;
        endcase
    end

    // Bit counter and payload shift register.
    // Bits enter at the MSB and shift right, so after DATA_BITS samples the
    // first (LSB) bit sits at bit 0 -- same result as writing shift[bit_cnt].
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            if (cnt_clr) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (shift_en) begin
                shift <= (shift >> 1) | (DATA_BITS'(s) << (DATA_BITS - 1));
            end
        end
    end

    // Output register, status pulses and registered busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= stop_good && rx_valid && !rx_ready;
            busy      <= (state_next == DATA) || (state_next == STOP);
            if (stop_good && (!rx_valid || rx_ready)) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
